// File: rtl/rcu_bit_sequencer.sv
// -----------------------------------------------------------------------------
// rcu_bit_sequencer
//   Receiver control unit for the UART receive path. Synchronises the raw
//   serial line, detects a start bit, confirms it at mid-bit, then issues one
//   shift_strobe at the centre of each following bit (data bits + stop bit).
//   Once the frame is in, the stop bit held by the shift register is checked:
//   a good stop bit pulses load_buffer, a bad one raises framing_error.
//   data_ready / overrun_error track the state of the downstream buffer.
//
// Ports
//   clk           system clock, rising edge
//   n_rst         asynchronous active-low reset
//   serial_in     raw serial line, idle high, asynchronous to clk
//   stop_bit      stop bit as presented by the receive shift register
//   data_read     consumer has read the receive buffer (one-cycle pulse)
//   shift_strobe  one-cycle pulse, shift register captures the serial bit
//   load_buffer   one-cycle pulse, receive buffer captures the packet
//   data_ready    buffer holds an unread byte
//   framing_error last frame had a stop bit of 0
//   overrun_error a byte was loaded while data_ready was still set
//   busy          sequencer is not idle
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module rcu_bit_sequencer #(
  parameter int CLKS_PER_BIT = 10,  // even, >= 4
  parameter int NUM_BITS     = 9    // strobes per frame after the start bit
) (
  input  logic clk,
  input  logic n_rst,
  input  logic serial_in,
  input  logic stop_bit,
  input  logic data_read,
  output logic shift_strobe,
  output logic load_buffer,
  output logic data_ready,
  output logic framing_error,
  output logic overrun_error,
  output logic busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(NUM_BITS + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(NUM_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    RECV,
    CHECK,
    LOAD
  } state_t;

  state_t        state;
  logic [CW-1:0] clk_cnt;
  logic [BW-1:0] bit_cnt;

  logic sync_q;
  logic line_s;
  logic line_prev;
  logic start_det;

  // Two-flop synchroniser plus one flop of edge history. The history runs in
  // every state so that a start edge is judged against a fresh previous sample
  // the moment the sequencer returns to IDLE.
  // NOTE: these flops reset to 1 (the idle line level) rather than 0, so that
  // leaving reset with the line idle cannot look like a falling edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q    <= 1'b1;
      line_s    <= 1'b1;
      line_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make the three flops shift as a chain;
      // blocking ones would collapse them into a single stage.
      sync_q    <= serial_in;
      line_s    <= sync_q;
      line_prev <= line_s;
    end
  end

  assign start_det = line_prev & ~line_s;

  // Sequencer and status flags.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      clk_cnt       <= '0;
      bit_cnt       <= '0;
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      // A read clears the status unless a new byte lands in the same cycle;
      // the LOAD branch below owns the flags in that case.
      if (data_read && state != LOAD) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end

      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          if (start_det) state <= START;
        end

        START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            if (!line_s) begin
              state         <= RECV;
              framing_error <= 1'b0;
            end else begin
              state <= IDLE;  // glitch, not a real start bit
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end

        RECV: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              state   <= CHECK;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end

        // The shift register took the last bit on the previous edge, so its
        // stop bit is valid now.
        CHECK: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          if (stop_bit) begin
            state <= LOAD;
          end else begin
            framing_error <= 1'b1;
            state         <= IDLE;
          end
        end

        LOAD: begin
          clk_cnt    <= '0;
          bit_cnt    <= '0;
          data_ready <= 1'b1;
          if (data_ready && !data_read) overrun_error <= 1'b1;
          state <= IDLE;
        end

        default: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Moore-decoded pulses: functions of registered state only, never of the
  // serial line.
  assign shift_strobe = (state == RECV) && (clk_cnt == BIT_LAST);
  assign load_buffer  = (state == LOAD);
  assign busy         = (state != IDLE);

endmodule

// File: doc/rcu_bit_sequencer.md
Name: rcu_bit_sequencer

Overview:
- Receiver control unit for the UART receive path.
- Detects a start bit on the serial line and times bit-centre sampling.
- Issues one shift_strobe per bit to the 9-bit receive shift register (8 data bits + stop bit; that register resets to all ones).
- After the frame, checks the stop bit the register presents, then either pulses load_buffer or flags a framing error. It also tracks data_ready and overrun status for the downstream consumer.

Parameters:
- CLKS_PER_BIT, 10, clock cycles per serial bit period; must be even and >= 4.
- NUM_BITS, 9, shift strobes per frame after the start bit (8 data + 1 stop).

Ports:
- clk  input  1  system clock, all state on rising edge
- n_rst  input  1  asynchronous active-low reset
- serial_in  input  1  raw serial line; idle high, asynchronous to clk
- stop_bit  input  1  stop bit output of the receive shift register (MSB position)
- data_read  input  1  consumer has read the receive buffer; single-cycle pulse
- shift_strobe  output  1  one-cycle pulse; shift register captures serial bit
- load_buffer  output  1  one-cycle pulse; receive buffer captures packet data
- data_ready  output  1  buffer holds an unread byte
- framing_error  output  1  last frame had stop bit = 0
- overrun_error  output  1  a new byte was loaded while data_ready was still set
- busy  output  1  high in any state other than IDLE

Behaviour:
Reset:
- Asynchronous reset, all outputs 0.
- Synchronizer flops and previous-sample flop reset to 1.
- State = IDLE; counters = 0.
- Reset asserted mid-frame aborts the frame with no strobe, load or error afterwards.

Input synchronization and start detection:
- serial_in passes through a 2-flop synchronizer, giving line_s.
- Start detected in IDLE when the previous line_s = 1 and the current line_s = 0.

Counters:
- clk_cnt is $clog2(CLKS_PER_BIT) bits wide.
- bit_cnt is $clog2(NUM_BITS+1) bits wide.
- Both are cleared on every state entry.

States:
- IDLE: wait for start detect, then go to START with clk_cnt = 0.
- START:
  - clk_cnt counts 0..CLKS_PER_BIT/2-1.
  - At terminal count, sample line_s.
  - If 1: false start; return to IDLE, no outputs change.
  - If 0: valid start; clear framing_error, go to RECV.
- RECV:
  - clk_cnt counts 0..CLKS_PER_BIT-1, then wraps.
  - shift_strobe = 1 exactly in the cycle clk_cnt = CLKS_PER_BIT-1; bit_cnt increments in the same cycle.
  - Strobes are therefore spaced exactly CLKS_PER_BIT cycles apart. The first strobe comes CLKS_PER_BIT cycles after start confirmation, at the centre of data bit 0.
  - After strobe number NUM_BITS, go to CHECK.
- CHECK:
  - Lasts one cycle; the shift register has absorbed the last bit, so stop_bit is valid.
  - stop_bit = 1: go to LOAD.
  - stop_bit = 0: framing_error set to 1 next cycle, no load, go to IDLE.
- LOAD:
  - Lasts one cycle: load_buffer = 1, data_ready set next cycle.
  - overrun_error is set next cycle if data_ready = 1 and data_read = 0 in this cycle.
  - Go to IDLE.

Status rules:
- data_read with no simultaneous load clears data_ready and overrun_error next cycle.
- data_read in the LOAD cycle: data_ready remains 1 and overrun_error is not set.
- framing_error persists until the next valid start confirmation or reset.
- A start edge during CHECK or LOAD is ignored. Start detection is armed only in IDLE, using edge history maintained continuously.
- Outputs are registered or Moore-decoded from the state; no output depends combinationally on serial_in.

Test Plan:
- Reset/idle: assert n_rst = 0 with serial_in = 0 → all outputs 0; release and hold serial_in = 1 for 50 clocks → no strobe, busy = 0.
- Good frame (CLKS_PER_BIT = 10): send start, data 0xA5 LSB-first, stop = 1 at 10 clocks/bit, with the shift register model feeding stop_bit.
  - Exactly 9 shift_strobe pulses, 10 clocks apart.
  - One load_buffer pulse two cycles after the 9th strobe; data_ready = 1; framing_error = 0.
- Framing error: same frame with stop = 0 → 9 strobes, no load_buffer, framing_error = 1, data_ready unchanged. Next good frame → framing_error clears at its start confirmation.
- False start: serial_in low for 3 clocks, then high → busy pulses, returns to IDLE, zero strobes, no flags.
- Overrun and read: two good frames with no data_read → second load sets overrun_error = 1. Pulse data_read → data_ready = 0 and overrun_error = 0 next cycle. Then data_read coincident with a LOAD cycle → data_ready = 1, overrun_error = 0.
- Reset mid-frame: assert n_rst after the 4th strobe → outputs 0 immediately. Release and send a full good frame → exactly 9 strobes and one load.
